// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the sequenced control unit.
//   - 3-bit opcode encodings (OP_STP .. OP_LD)
//   - sequencer state enum
//   - decode bundle width and bit positions {branch, ld, wrt_reg, wrt_mem, immed}
//   - registered output struct used by ctrl_seq
package ctrl_pkg;

  localparam logic [2:0] OP_STP  = 3'b000;
  localparam logic [2:0] OP_SHF  = 3'b001;
  localparam logic [2:0] OP_BNEG = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_ST   = 3'b110;
  localparam logic [2:0] OP_LD   = 3'b111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    LOAD_WAIT = 2'd2,
    HALT      = 2'd3
  } ctrl_state_e;

  localparam int BUNDLE_W    = 5;
  localparam int BIT_BRANCH  = 4;
  localparam int BIT_LD      = 3;
  localparam int BIT_WRT_REG = 2;
  localparam int BIT_WRT_MEM = 1;
  localparam int BIT_IMMED   = 0;

  // Every control output of ctrl_seq, registered as one word.
  typedef struct packed {
    logic pc_adv;
    logic branch_taken;
    logic ld_inst;
    logic wrt_reg;
    logic wrt_mem;
    logic immed;
    logic stall;
    logic illegal;
    logic done;
  } ctrl_out_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder.
// Ports:
//   opcode  in  OPCODE_W  opcode field of the fetched instruction
//   bundle  out BUNDLE_W  {branch, ld, wrt_reg, wrt_mem, immed}
//   is_stp  out 1         opcode is stp (legal)
//   illegal out 1         opcode not in the map (non-zero upper bits)
import ctrl_pkg::*;

module ctrl_decode #(
  parameter int OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [BUNDLE_W-1:0] bundle,
  output logic                is_stp,
  output logic                illegal
);

  logic upper_nz;

  always_comb begin
    // Opcode bits above the 3-bit map must be zero for a legal instruction.
    upper_nz = (opcode >> 3) != '0;
    bundle   = '0;
    is_stp   = 1'b0;
    illegal  = upper_nz;
    if (!upper_nz) begin
      case (opcode[2:0])
        OP_STP:                  is_stp = 1'b1;
        OP_SHF, OP_NOR, OP_ADD:  bundle = 5'b00100;
        OP_ADDI:                 bundle = 5'b00101;
        OP_ST:                   bundle = 5'b00010;
        OP_BNEG:                 bundle = 5'b10000;
        OP_LD:                   bundle = 5'b01100;
        default:                 illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: sequenced control unit. Decodes each valid instruction and drives
// registered one-cycle control pulses; FSM handles start/halt, multi-cycle
// loads (with datapath stall) and flag-qualified branches.
// Ports:
//   clk, reset (async, active-high)   start: leave IDLE or HALT
//   instr/instr_valid: instruction from ROM; flag_neg/flag_zero sampled with it
//   pc_adv, branch_taken, ld_inst, wrt_reg, wrt_mem, immed, stall, illegal,
//   done: registered control outputs (done is held while halted)
// Handshake: instr is consumed on a rising edge where instr_valid=1 and the
// unit is in RUN; there is no back-pressure, stall tells upstream to hold.
import ctrl_pkg::*;

module ctrl_seq #(
  parameter int INSTR_W     = 9,
  parameter int OPCODE_W    = 3,
  parameter int LD_WAIT     = 2,
  parameter int BR_FLAG_SEL = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic               flag_neg,
  input  logic               flag_zero,
  output logic               pc_adv,
  output logic               branch_taken,
  output logic               ld_inst,
  output logic               wrt_reg,
  output logic               wrt_mem,
  output logic               immed,
  output logic               stall,
  output logic               illegal,
  output logic               done
);

  localparam int CNT_W = (LD_WAIT > 0) ? $clog2(LD_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LD_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  ctrl_out_t            out_q, out_d;

  logic [BUNDLE_W-1:0]  dec_bundle;
  logic                 dec_stp;
  logic                 dec_illegal;
  logic                 br_flag;
  logic                 unused_instr_bits;

  // Operand bits are consumed by the datapath, not here.
  assign unused_instr_bits = ^instr[INSTR_W-OPCODE_W-1:0];
  assign br_flag = (BR_FLAG_SEL != 0) ? flag_zero : flag_neg;

  ctrl_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .opcode (instr[INSTR_W-1 -: OPCODE_W]),
    .bundle (dec_bundle),
    .is_stp (dec_stp),
    .illegal(dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (instr_valid) begin
          if (dec_illegal) begin
            out_d.pc_adv  = 1'b1;
            out_d.illegal = 1'b1;
          end else if (dec_stp) begin
            state_d    = HALT;
            out_d.done = 1'b1;
          end else if (dec_bundle[BIT_LD] && (LD_WAIT > 0)) begin
            state_d       = LOAD_WAIT;
            cnt_d         = CNT_LOAD;
            out_d.ld_inst = 1'b1;
            out_d.stall   = 1'b1;
          end else begin
            out_d.pc_adv       = 1'b1;
            out_d.branch_taken = dec_bundle[BIT_BRANCH] & br_flag;
            out_d.ld_inst      = dec_bundle[BIT_LD];
            out_d.wrt_reg      = dec_bundle[BIT_WRT_REG];
            out_d.wrt_mem      = dec_bundle[BIT_WRT_MEM];
            out_d.immed        = dec_bundle[BIT_IMMED];
          end
        end
      end
      LOAD_WAIT: begin
        // Last wait cycle: the read data is ready, write it back and advance.
        if (cnt_q <= CNT_ONE) begin
          state_d       = RUN;
          cnt_d         = '0;
          out_d.ld_inst = 1'b1;
          out_d.wrt_reg = 1'b1;
          out_d.pc_adv  = 1'b1;
        end else begin
          cnt_d         = cnt_q - CNT_ONE;
          out_d.ld_inst = 1'b1;
          out_d.stall   = 1'b1;
        end
      end
      HALT: begin
        if (start) state_d = RUN;
        else       out_d.done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign pc_adv       = out_q.pc_adv;
  assign branch_taken = out_q.branch_taken;
  assign ld_inst      = out_q.ld_inst;
  assign wrt_reg      = out_q.wrt_reg;
  assign wrt_mem      = out_q.wrt_mem;
  assign immed        = out_q.immed;
  assign stall        = out_q.stall;
  assign illegal      = out_q.illegal;
  assign done         = out_q.done;

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
Parametrised, sequenced successor to the combinational control decoder. It decodes the opcode field of each fetched instruction and drives registered one-cycle control pulses to the datapath and fetch unit. It owns a small FSM for start/halt sequencing, multi-cycle loads with datapath stall, and flag-qualified branches. It sits between instruction ROM and the fetch unit / register file / data memory.

Parameters:
INSTR_W, 9, instruction width in bits
OPCODE_W, 3, opcode width; opcode = instr[INSTR_W-1 -: OPCODE_W]; must be >= 3
LD_WAIT, 2, data-memory read wait cycles for ld (0..15); 0 = single-cycle load
BR_FLAG_SEL, 0, branch condition: 0 = flag_neg, 1 = flag_zero

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs
start  in  1  level/pulse; leaves IDLE or HALT
instr  in  INSTR_W  machine code from instruction ROM
instr_valid  in  1  instr valid this cycle
flag_neg  in  1  ALU negative flag, sampled with instr
flag_zero  in  1  ALU zero flag, sampled with instr
pc_adv  out  1  fetch unit advances (or takes branch) this cycle
branch_taken  out  1  fetch unit loads branch target
ld_inst  out  1  data-memory read active / reg write source = memory
wrt_reg  out  1  register file write enable
wrt_mem  out  1  data-memory write enable
immed  out  1  ALU operand B = immediate
stall  out  1  hold fetch and datapath pipeline registers
illegal  out  1  one-cycle pulse: unmapped opcode
done  out  1  sticky; set in HALT

Behaviour:
- All outputs registered; reset value 0 for every output, state = IDLE, wait counter = 0.
- Opcode map (low 3 bits of opcode; upper opcode bits, if any, must be 0, else illegal): 000 stp, 001 shf, 011 nor, 010 bneg, 110 st, 100 add, 101 addi, 111 ld.
- Decode bundle {branch, ld, wrt_reg, wrt_mem, immed}: shf/nor/add 00100; addi 00101; st 00010; bneg 10000; ld 01100; stp/illegal 00000.
- IDLE: outputs 0; instr_valid ignored; start=1 -> RUN next cycle.
- RUN, instr_valid=0: next-cycle outputs all 0 (bubble).
- RUN, instr_valid=1, latency 1: next cycle drives decoded bundle for exactly one cycle plus pc_adv=1, except:
  - bneg: branch_taken = selected flag sampled in the instr cycle; pc_adv=1 regardless.
  - stp: -> HALT; next cycle done=1, pc_adv=0, all others 0.
  - illegal: pc_adv=1, illegal=1, all others 0 (treated as nop).
  - ld with LD_WAIT>0: -> LOAD_WAIT, counter = LD_WAIT.
- LOAD_WAIT: ld_inst=1, stall=1, pc_adv=0, wrt_reg=0; counter decrements each cycle; instr_valid and start ignored. When counter = 1, next cycle: RUN, ld_inst=1, wrt_reg=1, pc_adv=1, stall=0. Stall is high exactly LD_WAIT cycles; ld completes LD_WAIT+1 cycles after sampling.
- LD_WAIT=0: ld behaves like a single-cycle op (ld_inst=1, wrt_reg=1, pc_adv=1, one cycle, no stall).
- HALT: done=1 held, all others 0; instr ignored; start=1 -> RUN, done cleared next cycle.
- start in RUN or LOAD_WAIT: ignored.
- reset mid-load or mid-branch: immediate IDLE, counter 0, no wrt_reg pulse issued.
- Counter width = max(1, $clog2(LD_WAIT+1)).

Decomposition:
- Package ctrl_pkg: opcode localparams (OP_STP..OP_LD), state enum {IDLE, RUN, LOAD_WAIT, HALT}, control-bundle width and bit-index constants.
- Sub-module ctrl_decode: combinational opcode -> bundle + illegal flag, parametrised by OPCODE_W; ctrl_seq holds FSM, counter and output registers.

Test Plan:
- reset, start, instr add (100_xxxxxx) valid -> next cycle wrt_reg=1, pc_adv=1, immed=0; following cycle all 0.
- LD_WAIT=2, instr ld -> cycles+1,+2: stall=1, ld_inst=1, pc_adv=0; cycle+3: wrt_reg=1, ld_inst=1, pc_adv=1, stall=0; instr_valid pulses during stall cause no outputs.
- bneg with flag_neg=1 -> branch_taken=1, pc_adv=1; with flag_neg=0 -> branch_taken=0; BR_FLAG_SEL=1 uses flag_zero instead.
- stp -> done=1 sticky, subsequent valid instrs give no pulses; start -> done=0, next add decodes normally.
- OPCODE_W=4, INSTR_W=10, opcode 1100 -> illegal=1, pc_adv=1, wrt_mem=0; opcode 0110 -> wrt_mem=1.
- reset asserted in second LOAD_WAIT cycle -> all outputs 0 asynchronously, no wrt_reg; start required to resume.
